muxn_rr: RTL and testbench

Parametrised N-input, W-bit registered stream multiplexer, the successor to the 2:1 combinational mux. It selects one of N valid/ready input channels, either by an external select or by round-robin arbitration, and forwards the chosen beat through a single output register stage. It sits in front of shared downstream consumers that need several producers merged onto one stream.

---
 rtl/muxn_pkg.sv | 29 ++
 rtl/muxn_rr_arb.sv | 51 +++++
 rtl/muxn_rr.sv | 117 +++++++++++
 tb/tb_muxn_rr.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared types, limits and the cyclic priority search used by the muxn_rr stream mux.
package muxn_pkg;

  localparam int MUXN_MAX_N = 16;

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_t;

  // Index of the first set bit of valid[0..n-1], scanning cyclically upward
  // from ptr; -1 when nothing is set. Lower scan offsets overwrite later.
  function automatic int rr_search(input logic [MUXN_MAX_N-1:0] valid,
                                   input int ptr,
                                   input int n);
    int idx;
    int res;
    res = -1;
    for (int k = MUXN_MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[3:0]]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/muxn_rr_arb.sv
// Grant generation for muxn_rr: fixed select, cyclic round-robin search, or a forced
// grant while a packet lock is held. Owns the round-robin pointer.
module muxn_rr_arb
  import muxn_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  input  logic [N-1:0]  in_valid,
  input  logic          locked,
  input  logic [SW-1:0] lock_ch,
  input  logic          advance,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt
);

  logic [SW-1:0] ptr;
  int            found;

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    found     = rr_search(MUXN_MAX_N'(in_valid), int'(ptr), N);
    if (locked) begin
      gnt_valid = 1'b1;
      gnt       = lock_ch;
    end else if (mode) begin
      if (found >= 0) begin
        gnt_valid = 1'b1;
        gnt       = SW'(found);
      end
    end else if (int'(sel) < N) begin
      // Fixed select grants regardless of that channel's valid.
      gnt_valid = 1'b1;
      gnt       = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && mode) begin
      ptr <= (int'(gnt) == N - 1) ? '0 : gnt + SW'(1);
    end
  end

endmodule

// File: rtl/muxn_rr.sv
// N-input registered valid/ready stream mux with fixed-select or round-robin arbitration.
// Define MUXN_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module muxn_rr
  import muxn_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic          load_ok;
  logic          gnt_valid;
  logic [SW-1:0] gnt;
  logic          xfer;
  logic [W-1:0]  sel_data;
  logic          sel_last;
  logic          locked;
  logic [SW-1:0] lock_ch;

  assign load_ok = !out_valid || out_ready;

  muxn_rr_arb #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .locked    (locked),
    .lock_ch   (lock_ch),
    .advance   (xfer),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  always_comb begin
    in_ready = '0;
    if (gnt_valid) in_ready[gnt] = load_ok;
  end

  assign xfer     = gnt_valid && in_valid[gnt] && load_ok;
  assign sel_data = in_data[int'(gnt)*W +: W];
  assign sel_last = in_last[gnt];

`ifdef MUXN_PKT_LOCK_EN
  lock_state_t   state;
  lock_state_t   state_nxt;
  logic [SW-1:0] lock_ch_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
    end
  end

  // A beat that is both first and last is a single-beat packet: no lock.
  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    case (state)
      IDLE: begin
        if (xfer && !sel_last) begin
          state_nxt   = LOCKED;
          lock_ch_nxt = gnt;
        end
      end
      LOCKED: begin
        if (xfer && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign locked = (state == LOCKED);
`else
  assign locked  = 1'b0;
  assign lock_ch = '0;
`endif

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_sel   <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muxn_rr.sv
// Self-checking bench for muxn_rr: N=4 main instance with a scoreboard on its output
// stream, plus an N=5 instance for out-of-range fixed selects.
module tb_muxn_rr;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int SW  = 2;
  localparam int N5  = 5;
  localparam int SW5 = 3;

`ifdef MUXN_PKT_LOCK_EN
  localparam logic [3:0] LAST_PAT = 4'b1111;
`else
  localparam logic [3:0] LAST_PAT = 4'b0101;
`endif

  typedef struct packed {
    logic [W-1:0]  data;
    logic          last;
    logic [SW-1:0] sel;
  } beat_t;

  logic           clk;
  logic           rst;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  logic            mode5;
  logic [SW5-1:0]  sel5;
  logic [N5-1:0]   in_valid5;
  logic [N5*W-1:0] in_data5;
  logic [N5-1:0]   in_last5;
  logic [N5-1:0]   in_ready5;
  logic            out_valid5;
  logic [W-1:0]    out_data5;
  logic            out_last5;
  logic [SW5-1:0]  out_sel5;
  logic            out_ready5;

  int    checks   = 0;
  int    failures = 0;
  beat_t exp_q[$];

  muxn_rr #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  muxn_rr #(.N(N5), .W(W)) dut5 (
    .clk(clk), .rst(rst), .mode(mode5), .sel(sel5),
    .in_valid(in_valid5), .in_data(in_data5), .in_last(in_last5), .in_ready(in_ready5),
    .out_valid(out_valid5), .out_data(out_data5), .out_last(out_last5), .out_sel(out_sel5),
    .out_ready(out_ready5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every beat leaving the main instance is popped and compared.
  always @(negedge clk) begin
    beat_t got;
    beat_t want;
    if (!rst && out_valid && out_ready) begin
      got = '{data: out_data, last: out_last, sel: out_sel};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_unexpected got data=%h last=%b sel=%0d, required no beat",
                 got.data, got.last, got.sel);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL scoreboard got data=%h last=%b sel=%0d, required data=%h last=%b sel=%0d",
                   got.data, got.last, got.sel, want.data, want.last, want.sel);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] v);
    in_data[ch*W +: W] = v;
  endtask

  task automatic push(input logic [W-1:0] d, input logic l, input logic [SW-1:0] s);
    exp_q.push_back('{data: d, last: l, sel: s});
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    mode5     = 1'b0;
    sel5      = '0;
    in_valid5 = '0;
    in_last5  = '0;
    in_data5  = '0;
    out_ready5 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got %b, required 0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      failures++; $display("FAIL reset_out_data got %h, required 00", out_data);
    end
    checks++;
    if ({out_last, out_sel} !== 3'b000) begin
      failures++; $display("FAIL reset_last_sel got last=%b sel=%0d, required 0 0", out_last, out_sel);
    end
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++; $display("FAIL reset_in_ready got %b, required 0001", in_ready);
    end
    tick();
  endtask

  task automatic test_fixed_select();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_last = 4'b1111;
    set_ch(0, 8'h11); set_ch(1, 8'h22); set_ch(2, 8'hA5); set_ch(3, 8'h33);
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++; $display("FAIL fixed_in_ready got %b, required 0100", in_ready);
    end
    push(8'hA5, 1'b1, 2'd2);
    tick();
    in_valid = '0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_sel} !== {1'b1, 8'hA5, 2'd2}) begin
      failures++;
      $display("FAIL fixed_output got valid=%b data=%h sel=%0d, required 1 a5 2",
               out_valid, out_data, out_sel);
    end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
    for (int i = 0; i < N; i++) set_ch(i, 8'h10 + 8'(i));
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_ready !== (4'b0001 << (k % 4))) begin
        failures++;
        $display("FAIL rr_in_ready beat %0d got %b, required %b", k, in_ready, 4'b0001 << (k % 4));
      end
      push(8'h10 + 8'(k % 4), 1'b1, SW'(k % 4));
      tick();
    end
    in_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back_stall();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; in_last = LAST_PAT;
    for (int i = 0; i < N; i++) set_ch(i, 8'h40 + 8'(i));
    push(8'h40, LAST_PAT[0], 2'd0);
    tick();
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++; $display("FAIL stall_in_ready got %b, required 0000", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, out_sel} !== {1'b1, 8'h40, 2'd0} || in_ready !== 4'b0000) begin
        failures++;
        $display("FAIL stall_hold cycle %0d got valid=%b data=%h sel=%0d in_ready=%b, required 1 40 0 0000",
                 c, out_valid, out_data, out_sel, in_ready);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++; $display("FAIL release_in_ready got %b, required 0010", in_ready);
    end
    push(8'h41, LAST_PAT[1], 2'd1);
    tick();
    in_valid = '0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h41}) begin
      failures++;
      $display("FAIL release_reload got valid=%b data=%h, required 1 41", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL drain_out_valid got %b, required 0", out_valid);
    end
  endtask

  task automatic test_sel_range();
    do_reset();
    mode5 = 1'b0; in_valid5 = 5'b11111; in_last5 = 5'b11111; out_ready5 = 1'b1;
    for (int i = 0; i < N5; i++) in_data5[i*W +: W] = 8'h80 + 8'(i);
    for (int s = 5; s < 8; s++) begin
      sel5 = SW5'(s);
      #1;
      checks++;
      if (in_ready5 !== 5'b00000) begin
        failures++; $display("FAIL sel_range_in_ready sel=%0d got %b, required 00000", s, in_ready5);
      end
      tick();
      checks++;
      if (out_valid5 !== 1'b0) begin
        failures++; $display("FAIL sel_range_out_valid sel=%0d got %b, required 0", s, out_valid5);
      end
    end
    sel5 = 3'd4;
    #1;
    checks++;
    if (in_ready5 !== 5'b10000) begin
      failures++; $display("FAIL sel_top_in_ready got %b, required 10000", in_ready5);
    end
    tick();
    in_valid5 = '0;
    checks++;
    if ({out_valid5, out_data5, out_sel5} !== {1'b1, 8'h84, 3'd4}) begin
      failures++;
      $display("FAIL sel_top_output got valid=%b data=%h sel=%0d, required 1 84 4",
               out_valid5, out_data5, out_sel5);
    end
    tick();
  endtask

`ifdef MUXN_PKT_LOCK_EN
  task automatic test_lock();
    do_reset();
    mode = 1'b1; in_valid = 4'b0001; in_last = 4'b0001;
    set_ch(0, 8'h60); set_ch(1, 8'h71); set_ch(2, 8'h62);
    push(8'h60, 1'b1, 2'd0);
    tick();
    in_valid = 4'b0111; in_last = 4'b0100;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++; $display("FAIL lock_beat1_in_ready got %b, required 0010", in_ready);
    end
    push(8'h71, 1'b0, 2'd1);
    tick();
    set_ch(1, 8'h72);
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++; $display("FAIL lock_beat2_in_ready got %b, required 0010", in_ready);
    end
    push(8'h72, 1'b0, 2'd1);
    tick();
    in_valid = 4'b0101;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++; $display("FAIL lock_idle_in_ready got %b, required 0010", in_ready);
    end
    tick();
    in_valid = 4'b0111; in_last = 4'b0110; set_ch(1, 8'h73);
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++; $display("FAIL lock_beat3_in_ready got %b, required 0010", in_ready);
    end
    push(8'h73, 1'b1, 2'd1);
    tick();
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++; $display("FAIL unlock_in_ready got %b, required 0100", in_ready);
    end
    push(8'h62, 1'b1, 2'd2);
    tick();
    in_valid = '0;
    tick();
    tick();
  endtask
`endif

  task automatic test_rst_mid_packet();
    do_reset();
    mode = 1'b1; in_valid = 4'b0100; in_last = 4'b0000;
    for (int i = 0; i < N; i++) set_ch(i, 8'h50 + 8'(i));
    tick();
    in_valid = '0; out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_out_valid got %b, required 0", out_valid);
    end
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++; $display("FAIL rst_mid_in_ready got %b, required 0001", in_ready);
    end
    push(8'h50, 1'b1, 2'd0);
    tick();
    in_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_fixed_select();
    test_round_robin();
    test_back_to_back_stall();
    test_sel_range();
`ifdef MUXN_PKT_LOCK_EN
    test_lock();
`endif
    test_rst_mid_packet();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drained got %0d pending beats, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
